csa_mult_seq: RTL

CSA_MULT_SEQ -- requirements
Module: csa_mult_seq

---
 rtl/csa_mult_pkg.sv | 14 +
 rtl/parameterized_csa.sv | 19 +
 rtl/csa_mult_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/csa_mult_pkg.sv
// Shared types and constants for the sequential carry-save multiplier.
package csa_mult_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned MIN_WIDTH = 2;
  localparam int unsigned MAX_WIDTH = 32;

endpackage

// File: rtl/parameterized_csa.sv
// Bitwise 3:2 carry-save compressor: sum/carry vectors whose total equals x+y+z modulo 2^WIDTH.
module parameterized_csa #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] z_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  logic [WIDTH-1:0] maj;

  assign sum_o   = x_i ^ y_i ^ z_i;
  assign maj     = (x_i & y_i) | (x_i & z_i) | (y_i & z_i);
  // Majority moves up one weight; the bit leaving the top is dropped.
  assign carry_o = {maj[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/csa_mult_seq.sv
// Sequential unsigned multiplier: one partial product folded into a carry-save
// pair per cycle, then a single carry-propagate add resolves the product.
module csa_mult_seq
  import csa_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  state_t          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [PW-1:0]   s_q, s_d;
  logic [PW-1:0]   c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   prod_q, prod_d;

  logic [PW-1:0]   a_ext;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   csa_sum;
  logic [PW-1:0]   csa_carry;

  assign a_ext = {{WIDTH{1'b0}}, a_q};
  assign pp    = b_q[cnt_q] ? (a_ext << cnt_q) : '0;

  parameterized_csa #(
    .WIDTH (PW)
  ) u_csa (
    .x_i     (s_q),
    .y_i     (c_q),
    .z_i     (pp),
    .sum_o   (csa_sum),
    .carry_o (csa_carry)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        s_d = csa_sum;
        c_d = csa_carry;
        // Counter parks on the final step instead of wrapping.
        if (cnt_q == LAST_STEP) begin
          state_d = RESOLVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESOLVE: begin
        prod_d  = s_q + c_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign product   = prod_q;

endmodule
